// File: rtl/led_frame_sequencer.sv
// Frame sequencer for the 8x8 LED serial path: picks the current pattern-store frame, latches it
// at scan start and streams it MSB-first over valid/ready, one bit per bit tick.
module led_frame_sequencer #(
   parameter int unsigned NUM_FRAMES     = 17,
   parameter int unsigned ADDR_W         = 5,
   parameter int unsigned BITS_PER_FRAME = 16,
   parameter int unsigned BIT_W          = 4
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      bit_tick_in,
   input  logic                      frame_tick_in,
   input  logic                      button_in,
   input  logic                      step_in,
   input  logic [BITS_PER_FRAME-1:0] frame_data_in,
   output logic [ADDR_W-1:0]         frame_addr_out,
   output logic                      data_led_out,
   output logic                      data_valid_out,
   input  logic                      data_ready_in,
   output logic                      frame_done_out,
   output logic                      playing_out
);

   typedef enum logic [1:0] {
      StLoad,
      StWaitTick,
      StSend,
      StAdvance
   } state_e;

   state_e                    state_q, state_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic [BIT_W-1:0]          bit_idx_q, bit_idx_d;
   logic [BITS_PER_FRAME-1:0] shreg_q, shreg_d;
   logic                      pending_q, pending_d;
   logic                      led_q, led_d;
   logic                      valid_q, valid_d;
   logic                      done_q, done_d;
   logic                      playing_q, playing_d;
   logic                      btn_q;

   logic btn_rise;
   logic adv_req;

   // A button edge in the same cycle as step_in wins; the step is discarded.
   assign btn_rise = button_in & ~btn_q;
   assign adv_req  = playing_q ? frame_tick_in : (step_in & ~btn_rise);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      pending_d = pending_q | adv_req;
      led_d     = led_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
      playing_d = playing_q ^ btn_rise;

      unique case (state_q)
         StLoad: begin
            shreg_d   = frame_data_in;
            bit_idx_d = '0;
            state_d   = StWaitTick;
         end
         StWaitTick: begin
            if (bit_tick_in) begin
               valid_d = 1'b1;
               led_d   = shreg_q[BITS_PER_FRAME-1];
               state_d = StSend;
            end
         end
         StSend: begin
            if (valid_q && data_ready_in) begin
               valid_d   = 1'b0;
               shreg_d   = {shreg_q[BITS_PER_FRAME-2:0], 1'b0};
               bit_idx_d = bit_idx_q + BIT_W'(1);
               if (bit_idx_q == BIT_W'(BITS_PER_FRAME - 1)) begin
                  done_d  = 1'b1;
                  state_d = StAdvance;
               end else begin
                  state_d = StWaitTick;
               end
            end
         end
         StAdvance: begin
            if (pending_q) begin
               addr_d = (addr_q == ADDR_W'(NUM_FRAMES - 1)) ? '0 : addr_q + ADDR_W'(1);
            end
            // A request landing in this cycle is kept for the following scan.
            pending_d = adv_req;
            state_d   = StLoad;
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= StLoad;
         addr_q    <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         pending_q <= 1'b0;
         led_q     <= 1'b0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         playing_q <= 1'b1;
         btn_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         pending_q <= pending_d;
         led_q     <= led_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         playing_q <= playing_d;
         btn_q     <= button_in;
      end
   end

   assign frame_addr_out = addr_q;
   assign data_led_out   = led_q;
   assign data_valid_out = valid_q;
   assign frame_done_out = done_q;
   assign playing_out    = playing_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Randomized bench for led_frame_sequencer: a scan-level model queues expected frame bits and a
// negedge monitor checks every handshake, frame boundary, address and play state.
module tb_led_frame_sequencer;

   localparam int NF = 17;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bit_tick = 1'b0, frame_tick = 1'b0, button = 1'b0, step = 1'b0, ready = 1'b1;
   logic [15:0] frame_data;
   logic [4:0]  addr;
   logic        led, valid, done, playing;

   logic [15:0] pattern [NF];

   always #5 clk = ~clk;

   assign frame_data = pattern[addr];

   led_frame_sequencer dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .bit_tick_in    (bit_tick),
      .frame_tick_in  (frame_tick),
      .button_in      (button),
      .step_in        (step),
      .frame_data_in  (frame_data),
      .frame_addr_out (addr),
      .data_led_out   (led),
      .data_valid_out (valid),
      .data_ready_in  (ready),
      .frame_done_out (done),
      .playing_out    (playing)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scan-level reference model
   bit exp_q[$];
   int m_addr, hs_cnt, frames, wraps;
   bit m_pending, m_playing, m_btn_prev, m_adv_now;
   bit prev_rst, prev_valid, prev_hs, prev_led, prev_tick;

   task automatic push_frame(input int a);
      logic [15:0] w;
      w = pattern[a];
      for (int i = 15; i >= 0; i--) exp_q.push_back(w[i]);
   endtask

   always @(negedge clk) begin
      bit hs, req, rise, next_adv, exp_bit;
      if (prev_rst) begin
         check("rst_valid", valid, 0);
         check("rst_led", led, 0);
         check("rst_done", done, 0);
         check("rst_playing", playing, 1);
         check("rst_addr", addr, 0);
      end
      if (rst) begin
         m_addr = 0; m_pending = 0; m_playing = 1; m_btn_prev = 0; m_adv_now = 0;
         hs_cnt = 0;
         exp_q.delete();
         push_frame(0);
         prev_rst = 1; prev_valid = 0; prev_hs = 0; prev_led = 0; prev_tick = 0;
      end else begin
         check("playing", playing, m_playing);
         check("addr", addr, m_addr);
         check("frame_done", done, m_adv_now);
         if (prev_hs) check("valid_drop_after_hs", valid, 0);
         else if (prev_valid) begin
            check("valid_held", valid, 1);
            check("led_stable", led, prev_led);
         end else if (valid) check("valid_rise_needs_tick", prev_tick, 1);

         hs = valid & ready;
         next_adv = 0;
         if (hs) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL unexpected_bit: got %0b expected none at %0t", led, $time);
            end else begin
               exp_bit = exp_q.pop_front();
               check("serial_bit", led, exp_bit);
            end
            hs_cnt++;
            next_adv = (hs_cnt == 16);
         end

         rise = button & ~m_btn_prev;
         req  = m_playing ? frame_tick : (step & ~rise);
         if (m_adv_now) begin
            frames++;
            if (m_pending) begin
               if (m_addr == NF - 1) wraps++;
               m_addr = (m_addr + 1) % NF;
            end
            m_pending = req;
            hs_cnt = 0;
            push_frame(m_addr);
         end else begin
            m_pending = m_pending | req;
         end
         m_playing  = m_playing ^ rise;
         m_btn_prev = button;
         m_adv_now  = next_adv;
         prev_rst = 0; prev_valid = valid; prev_hs = hs; prev_led = led; prev_tick = bit_tick;
      end
   end

   int cyc = 0;

   task automatic run(input int n, input int tick_div, input int ft_pct, input int step_pct,
                      input int rdy_pct);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         bit_tick   = (tick_div > 0) && (cyc % tick_div == 0);
         frame_tick = ($urandom_range(99) < ft_pct);
         step       = ($urandom_range(99) < step_pct);
         ready      = ($urandom_range(99) < rdy_pct);
      end
   endtask

   initial begin
      for (int i = 0; i < NF; i++) pattern[i] = 16'($urandom);
      pattern[0] = 16'hA5C3;
      run(3, 0, 0, 0, 100);
      rst = 1'b0;
      // Free-running scans of frame 0, no advance requests
      run(200, 4, 0, 0, 100);
      // Occasional frame ticks, then frequent ones to drive address wrap
      run(300, 4, 1, 0, 100);
      run(3000, 2, 5, 0, 100);
      // Pause, hold button, frame ticks must be ignored, steps advance
      button = 1'b1;
      run(50, 2, 5, 0, 100);
      run(300, 2, 5, 1, 100);
      button = 1'b0;
      run(20, 2, 5, 1, 100);
      button = 1'b1;
      run(100, 2, 5, 1, 100);
      button = 1'b0;
      // Backpressure with random play/pause toggling
      for (int k = 0; k < 10; k++) begin
         button = 1'($urandom);
         run(200, 3, 2, 2, 30);
      end
      button = 1'b0;
      // Mid-operation resets
      for (int k = 0; k < 5; k++) begin
         run($urandom_range(400, 100), 2, 3, 1, 70);
         rst = 1'b1;
         run(1, 2, 0, 0, 100);
         rst = 1'b0;
      end
      run(200, 2, 0, 0, 100);
      check("frames_completed_min", (frames >= 30), 1);
      check("address_wrapped", (wraps >= 1), 1);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
